// File: rtl/sort_result_collector_if.sv
// Signal bundle between the collector, the merge sorter tree head and the downstream sink.
// Stream handshake: a word moves on a posedge where m_valid && m_ready; m_valid never drops while a word is pending.
interface sort_result_collector_if #(
    parameter int W  = 32,
    parameter int CW = 8
);
    logic          start;
    logic [W-1:0]  t_dout;
    logic          t_empty;
    logic          t_deq;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic          busy;
    logic          done;
    logic          order_err;

    modport slave (
        input  start, t_dout, t_empty, m_ready,
        output t_deq, m_data, m_valid, m_last, wr_cnt, rd_cnt, busy, done, order_err
    );

    modport master (
        output start, t_dout, t_empty, m_ready,
        input  t_deq, m_data, m_valid, m_last, wr_cnt, rd_cnt, busy, done, order_err
    );
endinterface

// File: rtl/sort_result_collector.sv
// Collects one sorted batch of N words from the tree head, flags any descent, then replays it downstream.
module sort_result_collector #(
    parameter int W  = 32,
    parameter int N  = 128,
    parameter int CW = $clog2(N + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sort_result_collector_if.slave bus,
    output logic [1:0]             dbg_state_o
);
    localparam int            AW       = $clog2(N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [W-1:0]  prev_q, prev_d;
    logic          order_err_q, order_err_d;
    logic          t_deq;
    logic [W-1:0]  mem_q [N];

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        prev_d      = prev_q;
        order_err_d = order_err_q;
        t_deq       = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d     = S_COLLECT;
                    wr_cnt_d    = '0;
                    rd_cnt_d    = '0;
                    order_err_d = 1'b0;
                end
            end
            S_COLLECT: begin
                t_deq = ~bus.t_empty;
                if (t_deq) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    prev_d   = bus.t_dout;
                    // The first word of a batch has no predecessor to compare against.
                    if ((wr_cnt_q != '0) && (bus.t_dout < prev_q)) begin
                        order_err_d = 1'b1;
                    end
                    if (wr_cnt_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (bus.m_ready) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            prev_q      <= '0;
            order_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            prev_q      <= prev_d;
            order_err_q <= order_err_d;
        end
    end

    // Batch storage carries no reset; contents are only read after a full batch is written.
    always_ff @(posedge clk) begin
        if (t_deq) begin
            mem_q[wr_cnt_q[AW-1:0]] <= bus.t_dout;
        end
    end

    assign bus.t_deq     = t_deq;
    assign bus.m_valid   = (state_q == S_DRAIN);
    assign bus.m_data    = (state_q == S_DRAIN) ? mem_q[rd_cnt_q[AW-1:0]] : '0;
    assign bus.m_last    = (state_q == S_DRAIN) && (rd_cnt_q == LAST_IDX);
    assign bus.wr_cnt    = wr_cnt_q;
    assign bus.rd_cnt    = rd_cnt_q;
    assign bus.busy      = (state_q == S_COLLECT) || (state_q == S_DRAIN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.order_err = order_err_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_sort_result_collector.sv
// Directed bench for sort_result_collector: queue-level model of the batch plus literal timing checks.
module tb_sort_result_collector;
    localparam int W  = 32;
    localparam int N  = 128;
    localparam int CW = $clog2(N + 1);

    localparam int P_IDLE    = 0;
    localparam int P_COLLECT = 1;
    localparam int P_DRAIN   = 2;
    localparam int P_DONE    = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    sort_result_collector_if #(.W(W), .CW(CW)) sr ();

    sort_result_collector #(.W(W), .N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (sr),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    // Stimulus state
    logic [W-1:0] tree_q [$];
    int           gap_mode = 0;
    int           rdy_mode = 0;
    int           rdy_ph   = 0;
    logic [3:0]   rdy_pat  = 4'b1001;

    // Model: batch phase, words in, words out, sticky descent flag, stream scoreboard
    int           m_phase = P_IDLE;
    int           n_in    = 0;
    int           n_out   = 0;
    bit           m_err   = 1'b0;
    logic [W-1:0] exp_q [$];

    // Measurements of the DUT relative to the accepted start
    int           k_cyc = 0;
    int           pops = 0, xfers = 0, lasts = 0;
    int           first_pop_off = -1, last_pop_off = -1, pop50_off = -1;
    int           done_off = -1, err_off = -1;
    logic [W-1:0] last_word = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = P_IDLE;
            n_in    = 0;
            n_out   = 0;
            m_err   = 1'b0;
            exp_q.delete();
        end else begin
            case (m_phase)
                P_IDLE, P_DONE: begin
                    if (sr.start) begin
                        m_phase = P_COLLECT;
                        n_in    = 0;
                        n_out   = 0;
                        m_err   = 1'b0;
                        exp_q.delete();
                    end
                end
                P_COLLECT: begin
                    if (!sr.t_empty) begin
                        if (n_in > 0 && sr.t_dout < exp_q[$]) m_err = 1'b1;
                        exp_q.push_back(sr.t_dout);
                        void'(tree_q.pop_front());
                        n_in++;
                        if (n_in == N) m_phase = P_DRAIN;
                    end
                end
                P_DRAIN: begin
                    if (sr.m_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                        if (n_out == N) m_phase = P_DONE;
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        check("t_deq", 64'(sr.t_deq), 64'(m_phase == P_COLLECT && !sr.t_empty));
        check("m_valid", 64'(sr.m_valid), 64'(m_phase == P_DRAIN));
        check("m_last", 64'(sr.m_last), 64'(m_phase == P_DRAIN && n_out == N - 1));
        check("wr_cnt", 64'(sr.wr_cnt), 64'(n_in));
        check("rd_cnt", 64'(sr.rd_cnt), 64'(n_out));
        check("busy", 64'(sr.busy), 64'(m_phase == P_COLLECT || m_phase == P_DRAIN));
        check("done", 64'(sr.done), 64'(m_phase == P_DONE));
        check("order_err", 64'(sr.order_err), 64'(m_err));
        if (m_phase == P_DRAIN) check("m_data", 64'(sr.m_data), 64'(exp_q[0]));
        if (!rst_n) check("m_data_rst", 64'(sr.m_data), 64'(0));

        if (sr.start && (m_phase == P_IDLE || m_phase == P_DONE)) begin
            k_cyc = cyc;
            pops = 0; xfers = 0; lasts = 0;
            first_pop_off = -1; last_pop_off = -1; pop50_off = -1;
            done_off = -1; err_off = -1;
        end
        if (sr.t_deq) begin
            if (pops == 0) first_pop_off = cyc - k_cyc;
            if (pops == 50) pop50_off = cyc - k_cyc;
            if (pops == N - 1) last_pop_off = cyc - k_cyc;
            pops++;
        end
        if (sr.m_valid && sr.m_ready) begin
            xfers++;
            if (sr.m_last) begin
                lasts++;
                last_word = sr.m_data;
            end
        end
        if (sr.done && done_off < 0) done_off = cyc - k_cyc;
        if (sr.order_err && err_off < 0) err_off = cyc - k_cyc;
    end

    task automatic drive_inputs();
        sr.t_empty = (tree_q.size() == 0) || (gap_mode != 0 && (cyc % 3) == 0);
        sr.t_dout  = (tree_q.size() > 0) ? tree_q[0] : W'($urandom());
        sr.m_ready = (rdy_mode != 0) ? rdy_pat[rdy_ph % 4] : 1'b1;
        rdy_ph++;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic pulse_start();
        sr.start = 1'b1;
        cycle();
        sr.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!sr.done && n < budget) begin
            cycle();
            n++;
        end
        check("done_timeout", 64'(sr.done), 64'(1));
    endtask

    task automatic wait_pops(input int target, input int budget);
        int n = 0;
        while (pops < target && n < budget) begin
            cycle();
            n++;
        end
        check("pops_timeout", 64'(pops >= target), 64'(1));
    endtask

    task automatic check_batch(input logic [W-1:0] last_exp);
        check("pop_count", 64'(pops), 64'(N));
        check("xfer_count", 64'(xfers), 64'(N));
        check("last_count", 64'(lasts), 64'(1));
        check("last_word", 64'(last_word), 64'(last_exp));
    endtask

    initial begin
        sr.start = 1'b0;
        for (int i = 0; i < 4; i++) tree_q.push_back(W'(32'hA5A5_0000 + i));
        drive_inputs();

        // Reset for 3 cycles, tree non-empty
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_t_deq", 64'(sr.t_deq), 64'(0));
        check("rst_m_valid", 64'(sr.m_valid), 64'(0));
        check("rst_m_last", 64'(sr.m_last), 64'(0));
        check("rst_busy", 64'(sr.busy), 64'(0));
        check("rst_done", 64'(sr.done), 64'(0));
        check("rst_order_err", 64'(sr.order_err), 64'(0));
        check("rst_wr_cnt", 64'(sr.wr_cnt), 64'(0));
        check("rst_rd_cnt", 64'(sr.rd_cnt), 64'(0));
        check("rst_m_data", 64'(sr.m_data), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(0));

        // Nominal batch 0..127, plus a start on the final transfer cycle
        tree_q.delete();
        for (int i = 0; i < N; i++) tree_q.push_back(W'(i));
        drive_inputs();
        pulse_start();
        repeat (255) cycle();
        sr.start = 1'b1;
        cycle();
        sr.start = 1'b0;
        repeat (4) cycle();
        check("nom_first_pop", 64'(first_pop_off), 64'(1));
        check("nom_last_pop", 64'(last_pop_off), 64'(128));
        check("nom_done_cycle", 64'(done_off), 64'(257));
        check("nom_done_held", 64'(sr.done), 64'(1));
        check("nom_order_err", 64'(sr.order_err), 64'(0));
        check_batch(W'(127));

        // Empty on every third cycle
        gap_mode = 1;
        tree_q.delete();
        for (int i = 0; i < N; i++) tree_q.push_back(W'(1000 + 3 * i));
        drive_inputs();
        pulse_start();
        wait_done(1000);
        check("gap_stalled", 64'(last_pop_off > 128), 64'(1));
        check("gap_order_err", 64'(sr.order_err), 64'(0));
        check_batch(W'(1000 + 3 * 127));
        gap_mode = 0;

        // Descent at word 50
        tree_q.delete();
        for (int i = 0; i < N; i++) begin
            if (i <= 48) tree_q.push_back(W'(0));
            else if (i == 49) tree_q.push_back(W'(32'h20));
            else if (i == 50) tree_q.push_back(W'(32'h10));
            else tree_q.push_back(W'(256 + i));
        end
        drive_inputs();
        pulse_start();
        wait_done(600);
        check("err_after_pop50", 64'(err_off), 64'(pop50_off + 1));
        check("err_cycle", 64'(err_off), 64'(52));
        check("err_held_done", 64'(sr.order_err), 64'(1));
        check_batch(W'(383));

        // Backpressure 1,0,0,1 with ignored starts mid-COLLECT and mid-DRAIN
        rdy_mode = 1;
        tree_q.delete();
        for (int i = 0; i < N; i++) tree_q.push_back(W'(5 * i + 7));
        drive_inputs();
        pulse_start();
        @(negedge clk);
        check("err_cleared", 64'(sr.order_err), 64'(0));
        wait_pops(30, 300);
        pulse_start();
        while (!(sr.m_valid && xfers >= 20) && !sr.done) cycle();
        pulse_start();
        wait_done(1000);
        check("bp_order_err", 64'(sr.order_err), 64'(0));
        check_batch(W'(5 * 127 + 7));
        rdy_mode = 0;

        // Asynchronous reset after 60 pops, then a fresh batch
        tree_q.delete();
        for (int i = 0; i < N; i++) tree_q.push_back(W'(2 * i));
        drive_inputs();
        pulse_start();
        wait_pops(60, 300);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_t_deq", 64'(sr.t_deq), 64'(0));
        check("mid_rst_busy", 64'(sr.busy), 64'(0));
        check("mid_rst_wr_cnt", 64'(sr.wr_cnt), 64'(0));
        check("mid_rst_m_valid", 64'(sr.m_valid), 64'(0));
        check("mid_rst_state", 64'(dbg_state), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) cycle();
        tree_q.delete();
        for (int i = 0; i < N; i++) tree_q.push_back(W'(3 * i + 1));
        drive_inputs();
        pulse_start();
        @(negedge clk);
        check("fresh_wr_cnt", 64'(sr.wr_cnt), 64'(0));
        check("fresh_t_deq", 64'(sr.t_deq), 64'(1));
        wait_done(600);
        check_batch(W'(3 * 127 + 1));

        repeat (2) cycle();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/sort_result_collector.md
# sort_result_collector

Drain-side controller for the merge sorter tree. It pops sorted 32-bit words from the tree's head FIFO whenever the tree is non-empty, stores one complete batch of N words, and checks the batch for non-decreasing order. It then replays the batch downstream over a valid/ready stream with a last-word marker. In the sorting system it replaces the hand-written dequeue/`out_cnt` logic of the top-level controller.

## Interface
- `W`, 32: data word width (bits).
- `N`, 128: words per sorted batch. `N` ≥ 2.
- `CW`, $clog2(N+1): width of the count outputs.

- `clk`  in  1  system clock, posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins collection of a batch. Accepted only in IDLE or DONE.
- `t_dout`  in  W  head word of the merge sorter tree. Meaningful only while `t_empty`=0.
- `t_empty`  in  1  tree head FIFO is empty.
- `t_deq`  out  1  pop the tree head at this posedge.
- `m_data`  out  W  output stream word.
- `m_valid`  out  1  `m_data` is valid.
- `m_ready`  in  1  downstream accepts `m_data`.
- `m_last`  out  1  marks the Nth (final) word of the batch.
- `wr_cnt`  out  CW  number of words collected in the current batch.
- `rd_cnt`  out  CW  number of words already accepted downstream.
- `busy`  out  1  high in COLLECT or DRAIN.
- `done`  out  1  batch fully delivered. Held until the next `start`.
- `order_err`  out  1  sticky flag: some collected word was smaller than its predecessor (unsigned compare).

## Operation
- Storage: N×W memory, written at `wr_cnt` and read at `rd_cnt`.
- States: IDLE, COLLECT, DRAIN, DONE.
- IDLE:
  - `t_deq`=0, `m_valid`=0.
  - `start` → COLLECT. Clear `wr_cnt`, `rd_cnt`, `order_err` and `done`.
- COLLECT:
  - `t_deq` = ~`t_empty` (combinational).
  - On each edge with `t_deq`=1: mem[`wr_cnt`] ← `t_dout`; `wr_cnt`+1; prev ← `t_dout`.
  - If `wr_cnt`≠0 and `t_dout` < prev, set `order_err`=1.
  - The pop taken while `wr_cnt`=N−1 moves the state to DRAIN. Exactly N pops per batch; no pop is ever issued in other states.
- DRAIN:
  - `m_valid`=1 and `m_data`=mem[`rd_cnt`] (combinational read).
  - `m_last` = (`rd_cnt`=N−1).
  - On an edge with `m_valid`&`m_ready`: `rd_cnt`+1. The transfer with `m_last`=1 moves the state to DONE.
- DONE:
  - `done`=1; `wr_cnt`=`rd_cnt`=N; `order_err` holds its value.
  - `start` → COLLECT, same clears as from IDLE.
- `start` is ignored in COLLECT and DRAIN.
- `t_empty` high in COLLECT stalls collection with no side effects.
- `m_ready` low in DRAIN holds `m_data` and `m_last` stable.
- `order_err` is diagnostic only and does not stop the batch.

## Timing
- Reset (`rst_n`=0, asynchronous, any state):
  - State IDLE.
  - `t_deq`, `m_valid`, `m_last`, `busy`, `done` and `order_err` all 0.
  - `wr_cnt`=`rd_cnt`=0 and `m_data`=0; memory contents are don't-care.
  - Takes effect immediately, even mid-COLLECT or mid-DRAIN. Words already popped are lost, and no further `t_deq` is issued until a new `start`.
- A `start` sampled at edge k puts the block in COLLECT from cycle k+1. `t_deq` can be high in cycle k+1.
- Pop semantics:
  - `t_deq` and `t_dout` are sampled at the same posedge; the tree advances its head on that edge.
  - Word accepted in cycle c appears in `wr_cnt` at c+1.
- Throughput: 1 word/cycle in, 1 word/cycle out.
  - With `t_empty`=0 continuously, the Nth pop happens in cycle k+N.
  - `m_valid` rises in cycle k+N+1.
  - With `m_ready`=1 continuously, `done` rises in cycle k+2N+1.
- `m_valid` never drops while a word is pending. There is no gap between accepted DRAIN words.
- Simultaneous events:
  - `start` in the same cycle as the final DRAIN transfer is ignored.
  - `start` in DONE takes priority over holding DONE.

## Test plan
- Reset values: hold `rst_n`=0 for 3 cycles, release → all outputs 0, `t_deq`=0 even with `t_empty`=0, state IDLE.
- Nominal batch: `start`, tree supplies 0,1,…,127 with `t_empty`=0, `m_ready`=1 → exactly 128 pops in cycles k+1..k+128. Stream carries 0..127 in order, `m_last` only on 127, `done`=1 at k+257, `order_err`=0.
- Empty gaps: `t_empty` high on every third cycle → `t_deq`=0 on those cycles, `wr_cnt` stalls, all 128 words still captured in order.
- Order check: word 50 = 0x10, word 49 = 0x20 → `order_err`=1 from the cycle after word 50 is popped. It persists through DONE and clears on the next `start`.
- Backpressure and start filtering: `m_ready` toggles 1,0,0,1 → `m_data` is stable while stalled and no words are lost or duplicated. A `start` pulsed mid-COLLECT and mid-DRAIN has no effect.
- Reset mid-operation: assert `rst_n`=0 after 60 pops → outputs return to reset values within the same cycle. A new `start` collects a fresh batch of 128 starting at `wr_cnt`=0.
